// File: rtl/sb_align_pkg.sv
// Shared encodings and width helpers for the per-lane word-alignment controller.
// Also used by the multi-lane generator/checker wrapper.
package sb_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HUNT   = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } align_state_t;

    // Bits needed to hold a counter that reaches max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sb_align_win_mon.sv
// Windowed error counter used while the lane is locked.
// Requests unlock when the errored-word count reaches its threshold within one window.
module sb_align_win_mon
    import sb_align_pkg::*;
#(
    parameter int UNLOCK_WINDOW = 64,
    parameter int BAD_TO_UNLOCK = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic word_val,
    input  logic err,
    output logic unlock
);

    localparam int WW = cnt_w(UNLOCK_WINDOW);
    localparam int BW = cnt_w(BAD_TO_UNLOCK);

    logic [WW-1:0] win_cnt_reg;
    logic [BW-1:0] bad_cnt_reg;
    logic          win_last;

    // The last word of a window is judged before the wrap clears the counts.
    assign unlock   = active && word_val && err && (bad_cnt_reg == BW'(BAD_TO_UNLOCK - 1));
    assign win_last = (win_cnt_reg == WW'(UNLOCK_WINDOW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_reg <= '0;
            bad_cnt_reg <= '0;
        end else if (!active || unlock || (word_val && win_last)) begin
            win_cnt_reg <= '0;
            bad_cnt_reg <= '0;
        end else if (word_val) begin
            win_cnt_reg <= win_cnt_reg + 1'b1;
            bad_cnt_reg <= bad_cnt_reg + BW'(err);
        end
    end

endmodule

// File: rtl/sb_prbs_align_ctrl.sv
// Per-lane alignment/lock controller: hunts for word alignment with RX slip pulses,
// declares lock, watches the error rate while locked and re-hunts on loss of lock.
module sb_prbs_align_ctrl
    import sb_align_pkg::*;
#(
    parameter int DATA_WIDTH    = 80,
    parameter int MAX_SLIPS     = DATA_WIDTH,
    parameter int SLIP_PULSE_W  = 2,
    parameter int SLIP_SETTLE   = 32,
    parameter int GOOD_TO_LOCK  = 64,
    parameter int UNLOCK_WINDOW = 64,
    parameter int BAD_TO_UNLOCK = 8
) (
    input  logic                           RX_CLK,
    input  logic                           SYS_RESET,
    input  logic                           RX_READY,
    input  logic                           WORD_VAL,
    input  logic                           PRBS_ERR_DET,
    input  logic                           RESTART,
    output logic                           RX_SLIP,
    output logic                           RX_ALIGN,
    output logic                           ALIGN_FAIL,
    output logic                           LOCK_LOST,
    output logic [$clog2(MAX_SLIPS+1)-1:0] SLIP_CNT,
    output logic [2:0]                     STATE
);

    localparam int SCW  = $clog2(MAX_SLIPS + 1);
    localparam int PW   = cnt_w(SLIP_PULSE_W);
    localparam int SETW = cnt_w(SLIP_SETTLE);
    localparam int GW   = cnt_w(GOOD_TO_LOCK);

    generate
        if (BAD_TO_UNLOCK > UNLOCK_WINDOW || SLIP_PULSE_W == 0) begin : g_param_err
            $error("sb_prbs_align_ctrl: illegal BAD_TO_UNLOCK/UNLOCK_WINDOW/SLIP_PULSE_W combination");
        end
    endgenerate

    align_state_t    state_reg, state_next;
    logic [SCW-1:0]  slip_cnt_reg, slip_cnt_next;
    logic [GW-1:0]   good_cnt_reg, good_cnt_next;
    logic [PW-1:0]   slip_tmr_reg, slip_tmr_next;
    logic [SETW-1:0] settle_tmr_reg, settle_tmr_next;
    logic            rx_slip_reg, rx_align_reg, align_fail_reg, lock_lost_reg;
    logic            unlock;

    sb_align_win_mon #(
        .UNLOCK_WINDOW(UNLOCK_WINDOW),
        .BAD_TO_UNLOCK(BAD_TO_UNLOCK)
    ) u_win_mon (
        .clk     (RX_CLK),
        .rst     (SYS_RESET),
        .active  (state_reg == ST_LOCKED),
        .word_val(WORD_VAL),
        .err     (PRBS_ERR_DET),
        .unlock  (unlock)
    );

    always_comb begin
        state_next      = state_reg;
        slip_cnt_next   = slip_cnt_reg;
        good_cnt_next   = good_cnt_reg;
        slip_tmr_next   = '0;
        settle_tmr_next = '0;
        if (!RX_READY) begin
            state_next    = ST_IDLE;
            slip_cnt_next = '0;
            good_cnt_next = '0;
        end else if (RESTART) begin
            state_next    = ST_HUNT;
            slip_cnt_next = '0;
            good_cnt_next = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    state_next    = ST_HUNT;
                    slip_cnt_next = '0;
                    good_cnt_next = '0;
                end
                ST_HUNT: begin
                    if (WORD_VAL && PRBS_ERR_DET) begin
                        good_cnt_next = '0;
                        state_next    = (slip_cnt_reg == SCW'(MAX_SLIPS)) ? ST_FAIL : ST_SLIP;
                    end else if (WORD_VAL) begin
                        if (good_cnt_reg == GW'(GOOD_TO_LOCK - 1)) begin
                            good_cnt_next = '0;
                            state_next    = ST_LOCKED;
                        end else begin
                            good_cnt_next = good_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    if (slip_tmr_reg == PW'(SLIP_PULSE_W - 1)) begin
                        state_next = ST_SETTLE;
                    end else begin
                        slip_tmr_next = slip_tmr_reg + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_tmr_reg == SETW'(SLIP_SETTLE - 1)) begin
                        state_next    = ST_HUNT;
                        good_cnt_next = '0;
                    end else begin
                        settle_tmr_next = settle_tmr_reg + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (unlock) begin
                        state_next    = ST_SLIP;
                        slip_cnt_next = '0;
                    end
                end
                ST_FAIL: begin
                    state_next = ST_FAIL;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
        // A slip is counted once, on entry, after any clear above has taken effect.
        if (state_next == ST_SLIP && state_reg != ST_SLIP && slip_cnt_next != SCW'(MAX_SLIPS)) begin
            slip_cnt_next = slip_cnt_next + 1'b1;
        end
    end

    always_ff @(posedge RX_CLK or posedge SYS_RESET) begin
        if (SYS_RESET) begin
            state_reg      <= ST_IDLE;
            slip_cnt_reg   <= '0;
            good_cnt_reg   <= '0;
            slip_tmr_reg   <= '0;
            settle_tmr_reg <= '0;
            rx_slip_reg    <= 1'b0;
            rx_align_reg   <= 1'b0;
            align_fail_reg <= 1'b0;
            lock_lost_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            slip_cnt_reg   <= slip_cnt_next;
            good_cnt_reg   <= good_cnt_next;
            slip_tmr_reg   <= slip_tmr_next;
            settle_tmr_reg <= settle_tmr_next;
            rx_slip_reg    <= (state_next == ST_SLIP);
            rx_align_reg   <= (state_next == ST_LOCKED);
            align_fail_reg <= (state_next == ST_FAIL);
            lock_lost_reg  <= (state_reg == ST_LOCKED) && (state_next == ST_SLIP);
        end
    end

    assign RX_SLIP    = rx_slip_reg;
    assign RX_ALIGN   = rx_align_reg;
    assign ALIGN_FAIL = align_fail_reg;
    assign LOCK_LOST  = lock_lost_reg;
    assign SLIP_CNT   = slip_cnt_reg;
    assign STATE      = state_reg;

endmodule

// File: tb/tb_sb_prbs_align_ctrl.sv
// Directed bench for sb_prbs_align_ctrl: a short per-cycle vector table for state handshakes,
// then hand-written sequences for lock, slip/settle, windowed unlock, slip exhaustion and reset.
module tb_sb_prbs_align_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0, val = 1'b0, err = 1'b0, restart = 1'b0;
    logic       slip, align, fail, lost;
    logic [6:0] slip_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sb_prbs_align_ctrl dut (
        .RX_CLK      (clk),
        .SYS_RESET   (rst),
        .RX_READY    (ready),
        .WORD_VAL    (val),
        .PRBS_ERR_DET(err),
        .RESTART     (restart),
        .RX_SLIP     (slip),
        .RX_ALIGN    (align),
        .ALIGN_FAIL  (fail),
        .LOCK_LOST   (lost),
        .SLIP_CNT    (slip_cnt),
        .STATE       (state)
    );

    typedef struct {
        logic       ready, val, err, restart;
        logic [2:0] st;
        logic       sl, al, fl, lo;
        logic [6:0] cnt;
    } vec_t;

    vec_t tbl[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int  words;
        int  slips;
        bit  prev_slip;
        bit  ok;
        logic [13:0] got, exp;

        //            rdy val err rst  st   sl al fl lo cnt
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 7'd1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 7'd1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 7'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 7'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};

        // Reset state
        step();
        step();
        chk("reset_outputs", int'({slip, align, fail, lost, slip_cnt, state}), 0);
        rst = 1'b0;

        // Per-cycle handshake vectors
        for (int i = 0; i < 13; i++) begin
            ready   = tbl[i].ready;
            val     = tbl[i].val;
            err     = tbl[i].err;
            restart = tbl[i].restart;
            step();
            got = {state, slip, align, fail, lost, slip_cnt};
            exp = {tbl[i].st, tbl[i].sl, tbl[i].al, tbl[i].fl, tbl[i].lo, tbl[i].cnt};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got st=%0d slip=%b align=%b fail=%b lost=%b cnt=%0d, expected st=%0d slip=%b align=%b fail=%b lost=%b cnt=%0d",
                         i, state, slip, align, fail, lost, slip_cnt,
                         tbl[i].st, tbl[i].sl, tbl[i].al, tbl[i].fl, tbl[i].lo, tbl[i].cnt);
            end else begin
                $display("vec%0d ok: st=%0d slip=%b cnt=%0d", i, state, slip, slip_cnt);
            end
        end
        restart = 1'b0;

        // 1: 64 clean words (with idle gaps carrying a stray error) lock the lane
        ready = 1'b1; val = 1'b0; err = 1'b0;
        step();
        chk("t1_hunt", state, 1);
        words = 0;
        for (int c = 0; words < 64 && c < 200; c++) begin
            if (c % 5 == 4) begin
                val = 1'b0; err = 1'b1;
            end else begin
                val = 1'b1; err = 1'b0; words++;
            end
            step();
            if (words == 63 && val) chk("t1_no_lock_at_63", align, 0);
        end
        val = 1'b0; err = 1'b0;
        chk("t1_align", align, 1);
        chk("t1_state_locked", state, 4);
        chk("t1_slip_cnt", slip_cnt, 0);
        $display("t1 lock: align=%b state=%0d", align, state);

        // 2: error on word 10 -> 2-cycle slip, 32 settle cycles ignoring errors, relock
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("t2_restart_hunt", state, 1);
        for (int i = 1; i <= 10; i++) begin
            val = 1'b1; err = (i == 10);
            step();
        end
        chk("t2_slip_state", state, 2);
        chk("t2_rx_slip_c1", slip, 1);
        chk("t2_slip_cnt", slip_cnt, 1);
        err = 1'b1;
        step();
        chk("t2_rx_slip_c2", slip, 1);
        step();
        chk("t2_rx_slip_off", slip, 0);
        chk("t2_settle", state, 3);
        ok = 1'b1;
        for (int i = 0; i < 31; i++) begin
            step();
            if (state != 3'd3 || slip) ok = 1'b0;
        end
        chk("t2_settle_held_32", ok, 1);
        step();
        chk("t2_back_to_hunt", state, 1);
        err = 1'b0;
        for (int i = 0; i < 63; i++) step();
        chk("t2_no_lock_at_63", align, 0);
        step();
        chk("t2_relock", align, 1);
        chk("t2_slip_cnt_kept", slip_cnt, 1);
        $display("t2 slip/settle/relock: align=%b slip_cnt=%0d", align, slip_cnt);

        // 3: two windows of 7 errors stay locked; 8th error on last word of third window unlocks
        for (int w = 0; w < 3; w++) begin
            ok = 1'b1;
            for (int i = 0; i < 64; i++) begin
                val = 1'b1;
                if (w < 2) err = (i == 1 || i == 3 || i == 5 || i == 7 || i == 9 || i == 11 || i == 63);
                else       err = (i < 7 || i == 63);
                step();
                if ((w < 2 || i < 63) && (!align || lost)) ok = 1'b0;
                if (i == 20) begin
                    val = 1'b0; err = 1'b1;
                    step();
                    if (!align || lost) ok = 1'b0;
                end
            end
            chk($sformatf("t3_w%0d_held_lock", w), ok, 1);
        end
        chk("t3_lock_lost", lost, 1);
        chk("t3_align_drop", align, 0);
        chk("t3_slip_state", state, 2);
        chk("t3_rx_slip", slip, 1);
        chk("t3_slip_cnt", slip_cnt, 1);
        val = 1'b0; err = 1'b0;
        step();
        chk("t3_lock_lost_1cyc", lost, 0);
        $display("t3 windowed unlock: state=%0d slip_cnt=%0d", state, slip_cnt);

        // 4: error on every word -> 80 slips then sticky FAIL; RESTART re-hunts
        restart = 1'b1;
        step();
        restart = 1'b0;
        val = 1'b1; err = 1'b1;
        slips = 0; prev_slip = 1'b0;
        for (int c = 0; !fail && c < 5000; c++) begin
            step();
            if (slip && !prev_slip) slips++;
            prev_slip = slip;
        end
        chk("t4_align_fail", fail, 1);
        chk("t4_slip_pulses", slips, 80);
        chk("t4_slip_cnt", slip_cnt, 80);
        chk("t4_state_fail", state, 5);
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (slip || !fail) ok = 1'b0;
        end
        chk("t4_fail_sticky_no_slip", ok, 1);
        restart = 1'b1;
        step();
        restart = 1'b0; val = 1'b0; err = 1'b0;
        chk("t4_restart_hunt", state, 1);
        chk("t4_fail_cleared", fail, 0);
        chk("t4_slip_cnt_cleared", slip_cnt, 0);
        $display("t4 exhaustion: slips=%0d", slips);

        // 5: RX_READY drop in the first cycle of a slip pulse
        val = 1'b1; err = 1'b1;
        step();
        chk("t5_slipping", slip, 1);
        ready = 1'b0;
        step();
        chk("t5_slip_truncated", slip, 0);
        chk("t5_idle", state, 0);
        chk("t5_slip_cnt", slip_cnt, 0);
        chk("t5_no_lock_lost", lost, 0);
        $display("t5 ready drop: state=%0d", state);

        // 6: asynchronous reset while locked clears outputs before the next edge
        ready = 1'b1; val = 1'b0; err = 1'b0;
        step();
        val = 1'b1;
        for (int i = 0; i < 64; i++) step();
        chk("t6_locked", align, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_align", align, 0);
        chk("t6_async_state", state, 0);
        $display("t6 async reset: align=%b state=%0d", align, state);
        step();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
